// File: rtl/win_tile_gen.sv
// win_tile_gen: slices a row of signed samples into overlapping 4-sample
// tiles (stride 2) for an F(2,3) Winograd core. Short or odd-length rows are
// completed with zero padding during a FLUSH phase that stalls the input.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// S_FILL   | row start, cnt_q = k samples held (0..3), no tile yet
// S_STREAM | first tile emitted, cnt_q = pend samples since last tile (0..1)
// S_FLUSH  | row ended early, cnt_q = zero samples still to shift in
module win_tile_gen #(
  parameter int DW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            out_valid,
  output logic [4*DW-1:0] out_tile,
  output logic            out_last
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [4*DW-1:0] win_q, win_d;
  logic [4*DW-1:0] tile_q, tile_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  logic            accept;
  logic [4*DW-1:0] win_in;
  logic [4*DW-1:0] win_zero;

  // Ready is withheld while padding so the next row cannot overlap the flush.
  assign in_ready = !rst && (state_q != S_FLUSH);
  assign accept   = in_valid && in_ready;
  assign win_in   = {win_q[3*DW-1:0], in_data};
  assign win_zero = {win_q[3*DW-1:0], {DW{1'b0}}};

  // Next-state, window shift and tile capture; the tile register only loads on emission.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    tile_d  = tile_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          win_d = win_in;
          if (cnt_q == 3'd3) begin
            tile_d  = win_in;
            valid_d = 1'b1;
            cnt_d   = 3'd0;
            if (in_last) begin
              last_d  = 1'b1;
              win_d   = '0;
              state_d = S_FILL;
            end else begin
              state_d = S_STREAM;
            end
          end else if (in_last) begin
            // k after this accept is cnt_q+1, so 4-k zeros remain.
            cnt_d   = 3'd3 - cnt_q;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          win_d = win_in;
          if (cnt_q == 3'd1) begin
            tile_d  = win_in;
            valid_d = 1'b1;
            cnt_d   = 3'd0;
            if (in_last) begin
              last_d  = 1'b1;
              win_d   = '0;
              state_d = S_FILL;
            end
          end else if (in_last) begin
            cnt_d   = 3'd1;
            state_d = S_FLUSH;
          end else begin
            cnt_d = 3'd1;
          end
        end
      end
      S_FLUSH: begin
        win_d = win_zero;
        if (cnt_q == 3'd1) begin
          tile_d  = win_zero;
          valid_d = 1'b1;
          last_d  = 1'b1;
          win_d   = '0;
          cnt_d   = 3'd0;
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = 3'd0;
        win_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any partial tile silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      cnt_q   <= 3'd0;
      win_q   <= '0;
      tile_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      tile_q  <= tile_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_tile  = tile_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_win_tile_gen.sv
// tb_win_tile_gen: directed rows plus randomized traffic checked against a
// row-level reference model (row sample list, tiles at every even length >= 4).
module tb_win_tile_gen;

  localparam int DW = 10;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            in_ready;
  logic            out_valid;
  logic [4*DW-1:0] out_tile;
  logic            out_last;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0]   row[$];
  int              fl = 0;
  logic            exp_valid = 1'b0;
  logic            exp_last  = 1'b0;
  logic [4*DW-1:0] exp_tile  = '0;

  win_tile_gen #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_tile  (out_tile),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*DW-1:0] last_four();
    int n;
    logic [DW-1:0] a, b, c, d;
    n = row.size();
    a = row[n-4];
    b = row[n-3];
    c = row[n-2];
    d = row[n-1];
    return {a, b, c, d};
  endfunction

  // Row-level model: a tile is due whenever the row (incl. padding) reaches an even length >= 4.
  task automatic model_edge(input logic r, input logic v, input logic [DW-1:0] d, input logic l);
    int n;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    if (r) begin
      row.delete();
      fl       = 0;
      exp_tile = '0;
    end else if (fl > 0) begin
      row.push_back('0);
      fl--;
      n = row.size();
      if (n >= 4 && (n % 2) == 0) begin
        exp_valid = 1'b1;
        exp_tile  = last_four();
        exp_last  = (fl == 0);
      end
      if (fl == 0) row.delete();
    end else if (v) begin
      row.push_back(d);
      n = row.size();
      if (n >= 4 && (n % 2) == 0) begin
        exp_valid = 1'b1;
        exp_tile  = last_four();
        exp_last  = l;
        if (l) row.delete();
      end else if (l) begin
        fl = (n < 4) ? (4 - n) : 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic l);
    rst      = r;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    #1;
    check("in_ready", 64'(in_ready), 64'(!r && fl == 0));
    @(posedge clk);
    model_edge(r, v, d, l);
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("out_last", 64'(out_last), 64'(exp_last));
    check("out_tile", 64'(out_tile), 64'(exp_tile));
  endtask

  task automatic send(input int s, input logic l);
    step(1'b0, 1'b1, DW'(s), l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  int emitted;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, DW'(33), 1'b0);

    // 4-sample start, then continuation and end of row on a completing sample
    send(2, 0); send(-10, 0); send(3, 0); send(4, 0);
    check("tile_2_-10_3_4", 64'(out_tile), 64'({10'(2), 10'(-10), 10'(3), 10'(4)}));
    send(-19, 0); send(-6, 0);
    check("tile_3_4_-19_-6", 64'(out_tile), 64'({10'(3), 10'(4), 10'(-19), 10'(-6)}));
    send(-9, 0); send(7, 1);
    check("tile_row_end_last", 64'(out_last), 64'(1));
    idle(2);

    // short row: one flush cycle
    send(5, 0); send(6, 0); send(7, 1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("tile_5_6_7_0", 64'(out_tile), 64'({10'(5), 10'(6), 10'(7), 10'(0)}));
    idle(1);

    // odd row of 5: tile then one flush
    send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("tile_3_4_5_0", 64'(out_tile), 64'({10'(3), 10'(4), 10'(5), 10'(0)}));

    // gaps plus a sample offered during flush, which must be ignored
    send(11, 0); idle(2); send(-12, 1);
    send(99, 0); send(98, 0);
    check("flush_ignores_input", 64'(out_tile), 64'({10'(11), 10'(-12), 10'(0), 10'(0)}));
    idle(1);

    // single-sample row: three flush cycles
    send(-512, 1); idle(3);
    check("tile_single", 64'(out_tile), 64'({10'(-512), 10'(0), 10'(0), 10'(0)}));

    // reset mid-row abandons the partial tile
    send(21, 0); send(22, 0); send(23, 0);
    step(1'b1, 1'b1, DW'(24), 1'b0);
    send(31, 0); send(32, 0); send(33, 0); send(34, 0);
    check("tile_after_reset", 64'(out_tile), 64'({10'(31), 10'(32), 10'(33), 10'(34)}));
    send(35, 0); send(36, 1);

    // reset during flush
    send(41, 0); send(42, 1);
    step(1'b1, 1'b0, '0, 1'b0);
    idle(4);

    // randomized traffic
    emitted = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r, v, l;
      logic [DW-1:0] d;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) == 0);
      d = DW'($urandom);
      step(r, v, d, l);
      if (exp_valid) emitted++;
    end
    check("random_emissions_seen", 64'(emitted > 50), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
